// File: rtl/icache.sv
// Direct-mapped instruction cache: one instruction per line, synchronous tag/data arrays, single-beat fills.
// Optional ICACHE_STATS_EN adds saturating hit/miss counters (o_hit_cnt, o_miss_cnt).
module icache #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              mem_submit,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_data,
  input  logic              i_inval,
  output logic              o_bus_req,
  output logic [ADDR_W-1:0] o_bus_addr,
  input  logic              i_bus_ack,
  input  logic [DATA_W-1:0] i_bus_data,
`ifdef ICACHE_STATS_EN
  output logic [15:0]       o_hit_cnt,
  output logic [15:0]       o_miss_cnt,
`endif
  output logic              o_busy
);

  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int LINES = 1 << IDX_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, FILL, RESP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [LINES-1:0]  valid;
  logic              inval_seen;
  logic [DATA_W-1:0] resp_data;

  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];
  logic [TAG_W-1:0]  rd_tag;
  logic [DATA_W-1:0] rd_data;

  logic [IDX_W-1:0]  idx_q;
  logic [TAG_W-1:0]  tag_q;
  logic              hit;
  logic              miss;
  logic              accept;
  logic              fill_done;

  assign idx_q     = addr_q[IDX_W-1:0];
  assign tag_q     = addr_q[ADDR_W-1:IDX_W];
  assign hit       = (state == LOOKUP) && valid[idx_q] && (rd_tag == tag_q);
  assign miss      = (state == LOOKUP) && !hit;
  // A new request may only be taken when idle or while the previous one is being acked.
  assign accept    = mem_submit && ((state == IDLE) || hit || (state == RESP));
  assign fill_done = (state == FILL) && i_bus_ack;

  always_comb begin
    mem_ack  = hit || (state == RESP);
    mem_data = (state == RESP) ? resp_data : rd_data;
    o_busy   = (state == FILL) || (state == RESP);
  end

  // NOTE: the arrays and their read registers carry no reset so they map onto RAM; the valid flops gate any stale content.
  always_ff @(posedge i_clk) begin
    if (fill_done) begin
      tag_mem[idx_q]  <= tag_q;
      data_mem[idx_q] <= i_bus_data;
    end
    if (accept) begin
      rd_tag  <= tag_mem[mem_addr[IDX_W-1:0]];
      rd_data <= data_mem[mem_addr[IDX_W-1:0]];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      o_bus_req  <= 1'b0;
      o_bus_addr <= '0;
      inval_seen <= 1'b0;
      resp_data  <= '0;
    end else begin
      if (accept) addr_q <= mem_addr;
      case (state)
        IDLE: begin
          if (accept) state <= LOOKUP;
        end
        LOOKUP: begin
          if (hit) begin
            state <= accept ? LOOKUP : IDLE;
          end else begin
            o_bus_req  <= 1'b1;
            o_bus_addr <= addr_q;
            inval_seen <= 1'b0;
            state      <= FILL;
          end
        end
        FILL: begin
          if (i_inval) inval_seen <= 1'b1;
          if (i_bus_ack) begin
            o_bus_req <= 1'b0;
            resp_data <= i_bus_data;
            state     <= RESP;
          end
        end
        RESP: begin
          state <= accept ? LOOKUP : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // An invalidate anywhere in the fill window leaves the refilled line invalid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid <= '0;
    end else if (i_inval) begin
      valid <= '0;
    end else if (fill_done && !inval_seen) begin
      valid[idx_q] <= 1'b1;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hit_cnt  <= '0;
      o_miss_cnt <= '0;
    end else begin
      if (hit && (o_hit_cnt != 16'hffff))   o_hit_cnt  <= o_hit_cnt + 16'd1;
      if (miss && (o_miss_cnt != 16'hffff)) o_miss_cnt <= o_miss_cnt + 16'd1;
    end
  end
`endif

endmodule
